lcd_score_writer: RTL and testbench
===================================

# lcd_score_writer

Upstream feeder for the `lcd` character-buffer controller. On a start pulse it latches a 16-bit score and 4-bit level and converts the score to five BCD digits. It writes a full 2×16 screen image into `lcd` through its `row`/`col`/`char`/`we` port, one character per cycle, then pulses `update` and waits for the LCD refresh to finish. It lets game logic refresh the display without knowing LCD timing or the character layout.

## Interface
- No parameters.
- `CLK`  in  1  system clock
- `RST`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request; accepted only while `ready`=1
- `score`  in  16  binary score, sampled on accepted `start`
- `level`  in  4  binary level 0–15, sampled on accepted `start`
- `ready`  out  1  high in IDLE only
- `done`  out  1  one-cycle pulse when the refresh completes
- `row`  out  1  buffer row to `lcd`
- `col`  out  4  buffer column to `lcd`
- `char`  out  8  ASCII character to `lcd`
- `we`  out  1  buffer write strobe to `lcd`
- `busy`  in  1  from `lcd`; high during LCD init and during update transfer
- `update`  out  1  one-cycle refresh request to `lcd`

## Operation
- FSM states: IDLE, CONV, WAIT_FREE, WRITE, UPD, WAIT_ACK, WAIT_DONE.
- IDLE: `ready`=1. When `start`=1, latch `score` and `level`, clear the BCD register, and go to CONV. `start` is ignored in every other state.
- CONV: double-dabble over 16 cycles. Each cycle, add 3 to every BCD nibble that is ≥5, then shift left one bit, taking in the score MSB. Result is 20 bits (5 digits). After 16 cycles, go to WAIT_FREE.
- WAIT_FREE: go to WRITE when `busy`=0.
- WRITE: 32 writes in order: row 0 cols 0–15, then row 1 cols 0–15. One write per cycle.
  - If `busy`=1, hold `we`=0 and keep the position. Resume at the same position when `busy` returns to 0.
- Screen image:
  - row 0: "SCORE" at cols 0–4, spaces at cols 5–10, digits ten-thousands…units at cols 11–15.
  - row 1: "LEVEL" at cols 0–4, spaces at cols 5–13, level tens at col 14 ('0' or '1'; tens = level≥10), level units at col 15.
  - Digit character = 8'h30 + digit.
- After the write to row 1 col 15, go to UPD.
- UPD: when `busy`=0, assert `update` for exactly one cycle, then go to WAIT_ACK.
- WAIT_ACK: go to WAIT_DONE when `busy`=1. If `busy` does not rise within 4 cycles, go directly to WAIT_DONE.
- WAIT_DONE: when `busy`=0, pulse `done` for one cycle and go to IDLE.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `we`=0, `update`=0, `row`=0, `col`=0, `char`=8'h20, BCD register 0.
- Asserting `RST` in any state returns to IDLE immediately. A partial screen is left in the `lcd` buffer, and no `update` is issued.
- `start` accepted at edge N:
  - CONV occupies cycles N+1…N+16.
  - With `busy`=0 throughout, the first `we` is at cycle N+18.
  - The last `we` is at N+49.
  - `update` is at N+50.
- `row`, `col`, `char` and `we` are registered and change together. `row`/`col`/`char` are valid in every cycle in which `we`=1.
- `update` is never asserted in the same cycle as `we`.
- `done` and `ready` are both high in the cycle after WAIT_DONE exits. A `start` in that cycle is accepted.

## Configuration
- `LCD_SCORE_ZERO_BLANK_EN` defined: leading zero score digits (cols 11–14) are written as 8'h20. The units digit is always shown. Level tens is written as a space when 0.
- Not defined: all five score digits and both level digits are written, including leading '0's.

## Test plan
- Reset, then release with `busy`=0 -> `ready`=1, `we`=0, `update`=0, `char`=8'h20. No writes occur without `start`.
- `score`=0, `level`=3, blank enabled -> row 0 = "SCORE          0", row 1 = "LEVEL          3". Exactly 32 `we` pulses, one `update` at N+50, then `done`.
- `score`=65535, `level`=15, blank disabled -> row 0 cols 11–15 = "65535", row 1 cols 14–15 = "15".
- `score`=1234, `busy` forced high for 20 cycles starting at the 5th write -> writes pause at row 0 col 5 and resume with no skipped or duplicated position. `update` is issued only after `busy` falls.
- `start` pulsed during CONV with a different score -> ignored. The display shows the first score.
- `RST` asserted at the 10th write, then released -> IDLE, `we`=0, no `update`. A new `start` produces a full 32-write refresh.

Source files
------------

// File: rtl/lcd_score_writer.sv
// Converts a latched score/level to ASCII and streams a 2x16 screen image into the lcd buffer.
// Optional build macro LCD_SCORE_ZERO_BLANK_EN blanks leading zero score digits and a zero level tens digit.
module lcd_score_writer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [15:0] score,
  input  logic [3:0]  level,
  output logic        ready,
  output logic        done,
  output logic        row,
  output logic [3:0]  col,
  output logic [7:0]  char,
  output logic        we,
  input  logic        busy,
  output logic        update
);

  typedef enum logic [2:0] {
    IDLE, CONV, WAIT_FREE, WRITE, UPD, WAIT_ACK, WAIT_DONE
  } state_t;

  state_t      state, next_state;
  logic [15:0] bin_q;
  logic [3:0]  lvl_q;
  logic [19:0] bcd_q;
  logic [19:0] bcd_adj;
  logic [3:0]  conv_cnt;
  logic [4:0]  pos_q;
  logic [1:0]  ack_cnt;

  logic        accept;
  logic        conv_step;
  logic        write_fire;
  logic        upd_fire;
  logic        done_fire;
  logic [7:0]  wr_char;

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    next_state = state;
    case (state)
      IDLE:      if (start)                      next_state = CONV;
      CONV:      if (conv_cnt == 4'd15)          next_state = WAIT_FREE;
      WAIT_FREE: if (!busy)                      next_state = WRITE;
      WRITE:     if (!busy && pos_q == 5'd31)    next_state = UPD;
      UPD:       if (!busy)                      next_state = WAIT_ACK;
      WAIT_ACK:  if (busy || ack_cnt == 2'd3)    next_state = WAIT_DONE;
      WAIT_DONE: if (!busy)                      next_state = IDLE;
      default:                                   next_state = IDLE;
    endcase
  end

  // Output decode; the first write is launched on the WAIT_FREE exit edge
  always_comb begin
    ready      = (state == IDLE);
    accept     = (state == IDLE) && start;
    conv_step  = (state == CONV);
    write_fire = ((state == WAIT_FREE) || (state == WRITE)) && !busy;
    upd_fire   = (state == UPD) && !busy;
    done_fire  = (state == WAIT_DONE) && !busy;
  end

  // Double-dabble correction: bump every nibble >= 5 before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  logic [3:0] dig4, dig3, dig2, dig1, dig0;
  logic       lvl_tens;
  logic [3:0] lvl_units;
  logic [4:1] blank;
  logic       tens_blank;

  always_comb begin
    dig4      = bcd_q[19:16];
    dig3      = bcd_q[15:12];
    dig2      = bcd_q[11:8];
    dig1      = bcd_q[7:4];
    dig0      = bcd_q[3:0];
    lvl_tens  = (lvl_q >= 4'd10);
    lvl_units = lvl_tens ? (lvl_q - 4'd10) : lvl_q;
`ifdef LCD_SCORE_ZERO_BLANK_EN
    blank[4]   = (dig4 == 4'd0);
    blank[3]   = blank[4] && (dig3 == 4'd0);
    blank[2]   = blank[3] && (dig2 == 4'd0);
    blank[1]   = blank[2] && (dig1 == 4'd0);
    tens_blank = !lvl_tens;
`else
    blank      = 4'b0000;
    tens_blank = 1'b0;
`endif
  end

  // Screen image: pos[4] selects the row, pos[3:0] the column
  always_comb begin
    wr_char = 8'h20;
    case (pos_q)
      5'd0:  wr_char = "S";
      5'd1:  wr_char = "C";
      5'd2:  wr_char = "O";
      5'd3:  wr_char = "R";
      5'd4:  wr_char = "E";
      5'd11: wr_char = blank[4] ? 8'h20 : {4'h3, dig4};
      5'd12: wr_char = blank[3] ? 8'h20 : {4'h3, dig3};
      5'd13: wr_char = blank[2] ? 8'h20 : {4'h3, dig2};
      5'd14: wr_char = blank[1] ? 8'h20 : {4'h3, dig1};
      5'd15: wr_char = {4'h3, dig0};
      5'd16: wr_char = "L";
      5'd17: wr_char = "E";
      5'd18: wr_char = "V";
      5'd19: wr_char = "E";
      5'd20: wr_char = "L";
      5'd30: wr_char = tens_blank ? 8'h20 : {7'h18, lvl_tens};
      5'd31: wr_char = {4'h3, lvl_units};
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin_q    <= '0;
      lvl_q    <= '0;
      bcd_q    <= '0;
      conv_cnt <= '0;
      pos_q    <= '0;
      ack_cnt  <= '0;
      we       <= 1'b0;
      update   <= 1'b0;
      done     <= 1'b0;
      row      <= 1'b0;
      col      <= 4'd0;
      char     <= 8'h20;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      we      <= write_fire;
      update  <= upd_fire;
      done    <= done_fire;
      ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 2'd1 : 2'd0;
      if (accept) begin
        bin_q    <= score;
        lvl_q    <= level;
        bcd_q    <= '0;
        conv_cnt <= '0;
        pos_q    <= '0;
      end
      if (conv_step) begin
        bcd_q    <= {bcd_adj[18:0], bin_q[15]};
        bin_q    <= {bin_q[14:0], 1'b0};
        conv_cnt <= conv_cnt + 4'd1;
      end
      if (write_fire) begin
        row   <= pos_q[4];
        col   <= pos_q[3:0];
        char  <= wr_char;
        pos_q <= pos_q + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_score_writer.sv
// Scoreboard bench for lcd_score_writer: expected screen writes are queued at start and popped per we pulse.
module tb_lcd_score_writer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] score;
  logic [3:0]  level;
  logic        ready;
  logic        done;
  logic        row;
  logic [3:0]  col;
  logic [7:0]  char;
  logic        we;
  logic        busy;
  logic        update;

  lcd_score_writer dut (
    .CLK    (clk),
    .RST    (rst_n),
    .start  (start),
    .score  (score),
    .level  (level),
    .ready  (ready),
    .done   (done),
    .row    (row),
    .col    (col),
    .char   (char),
    .we     (we),
    .busy   (busy),
    .update (update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference screen entry {row, col, char} for one buffer position
  function automatic logic [12:0] model_entry(input int sc, input int lv, input int p);
    int         r, c, d;
    logic [7:0] ch;
    int         lim;
    logic [3:0] c4;
    r  = p / 16;
    c  = p % 16;
    ch = 8'h20;
    if (r == 0) begin
      case (c)
        0: ch = 8'h53;
        1: ch = 8'h43;
        2: ch = 8'h4F;
        3: ch = 8'h52;
        4: ch = 8'h45;
        default: ;
      endcase
      if (c >= 11) begin
        lim = (c == 11) ? 10000 : (c == 12) ? 1000 : (c == 13) ? 100 : (c == 14) ? 10 : 1;
        d   = (sc / lim) % 10;
        ch  = 8'(8'h30 + d);
`ifdef LCD_SCORE_ZERO_BLANK_EN
        if (c < 15 && sc < lim) ch = 8'h20;
`endif
      end
    end else begin
      case (c)
        0: ch = 8'h4C;
        1: ch = 8'h45;
        2: ch = 8'h56;
        3: ch = 8'h45;
        4: ch = 8'h4C;
        14: begin
          ch = 8'(8'h30 + lv / 10);
`ifdef LCD_SCORE_ZERO_BLANK_EN
          if (lv < 10) ch = 8'h20;
`endif
        end
        15: ch = 8'(8'h30 + lv % 10);
        default: ;
      endcase
    end
    c4 = 4'(c);
    return {r[0], c4, ch};
  endfunction

  logic [12:0] exp_q[$];
  int cyc          = 0;
  int acc_edge     = 0;
  int wr_cnt       = 0;
  int upd_cnt      = 0;
  int done_cnt     = 0;
  int first_we_per = 0;
  int last_we_per  = 0;
  int upd_per      = 0;
  bit first_pending = 0;
  logic busy_edge  = 1'b0;

  always @(posedge clk) begin
    cyc++;
    busy_edge = busy;
    if (rst_n && start && ready) acc_edge = cyc;
  end

  // Monitor: outputs seen here belong to the period ending at edge cyc+1
  always @(negedge clk) begin
    logic [12:0] e;
    if (rst_n) begin
      if (busy_edge) check("we_while_busy", 32'(we), 32'd0);
      if (we) begin
        wr_cnt++;
        last_we_per = cyc + 1;
        if (first_pending) begin
          first_we_per  = cyc + 1;
          first_pending = 0;
        end
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr", 32'({row, col, char}), 32'(e));
        end
      end
      if (update) begin
        upd_cnt++;
        upd_per = cyc + 1;
        check("upd_with_we", 32'(we), 32'd0);
      end
      if (done) begin
        done_cnt++;
        check("done_ready", 32'(ready), 32'd1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int sc, input int lv);
    int t;
    t = 0;
    while (!ready && t < 200) begin
      step();
      t++;
    end
    check("ready_before_start", 32'(ready), 32'd1);
    score = 16'(sc);
    level = 4'(lv);
    start = 1'b1;
    for (int p = 0; p < 32; p++) exp_q.push_back(model_entry(sc, lv, p));
    first_pending = 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_update(input int budget);
    int base, t;
    base = upd_cnt;
    t    = 0;
    while (upd_cnt == base && t < budget) begin
      step();
      t++;
    end
    if (upd_cnt == base) check("update_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int base, t;
    base = done_cnt;
    t    = 0;
    while (done_cnt == base && t < budget) begin
      step();
      t++;
    end
    if (done_cnt == base) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic lcd_ack(input int hold);
    busy = 1'b1;
    repeat (hold) step();
    busy = 1'b0;
  endtask

  task automatic wait_writes(input int base, input int n);
    int t;
    t = 0;
    while (wr_cnt - base < n && t < 200) begin
      step();
      t++;
    end
    check("write_progress", 32'(wr_cnt - base), 32'(n));
  endtask

  // Refresh with busy low during writing; checks the nominal timeline
  task automatic full_refresh(input int sc, input int lv);
    int bw, bu, bd;
    bw = wr_cnt;
    bu = upd_cnt;
    bd = done_cnt;
    issue(sc, lv);
    wait_update(100);
    check("first_we_offset", 32'(first_we_per - acc_edge), 32'd18);
    check("last_we_offset",  32'(last_we_per - acc_edge),  32'd49);
    check("update_offset",   32'(upd_per - acc_edge),      32'd50);
    lcd_ack(3);
    wait_done(50);
    check("write_count",  32'(wr_cnt - bw),   32'd32);
    check("update_count", 32'(upd_cnt - bu),  32'd1);
    check("done_count",   32'(done_cnt - bd), 32'd1);
    check("queue_empty",  32'(exp_q.size()),  32'd0);
  endtask

  initial begin
    int bw, bu, bd;
    rst_n = 1'b0;
    start = 1'b0;
    score = '0;
    level = '0;
    busy  = 1'b0;
    repeat (3) step();
    check("rst_we",     32'(we),     32'd0);
    check("rst_update", 32'(update), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_ready",  32'(ready),  32'd1);
    check("idle_we",     32'(we),     32'd0);
    check("idle_update", 32'(update), 32'd0);
    check("idle_done",   32'(done),   32'd0);
    check("idle_char",   32'(char),   32'h20);
    check("idle_rowcol", 32'({row, col}), 32'd0);
    repeat (10) step();
    check("no_write_idle", 32'(wr_cnt), 32'd0);

    full_refresh(0, 3);
    full_refresh(65535, 15);

    // busy rises after the 5th write and holds for 20 cycles
    bw = wr_cnt;
    bu = upd_cnt;
    issue(1234, 7);
    wait_writes(bw, 5);
    busy = 1'b1;
    repeat (20) step();
    check("pause_hold",    32'(wr_cnt - bw),  32'd5);
    check("pause_no_upd",  32'(upd_cnt - bu), 32'd0);
    busy = 1'b0;
    wait_update(100);
    lcd_ack(2);
    wait_done(50);
    check("pause_writes", 32'(wr_cnt - bw), 32'd32);
    check("pause_queue",  32'(exp_q.size()), 32'd0);

    // start during conversion is ignored; lcd never acks so the ack wait times out
    bw = wr_cnt;
    bd = done_cnt;
    issue(500, 9);
    repeat (5) step();
    score = 16'd999;
    level = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_update(100);
    wait_done(20);
    check("ign_writes", 32'(wr_cnt - bw),   32'd32);
    check("ign_done",   32'(done_cnt - bd), 32'd1);
    check("ign_queue",  32'(exp_q.size()),  32'd0);

    // reset in the middle of the screen write
    bw = wr_cnt;
    bu = upd_cnt;
    issue(42, 10);
    wait_writes(bw, 10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready",  32'(ready),  32'd1);
    check("mid_rst_we",     32'(we),     32'd0);
    check("mid_rst_update", 32'(update), 32'd0);
    exp_q.delete();
    first_pending = 0;
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    check("post_rst_writes", 32'(wr_cnt - bw),  32'd10);
    check("post_rst_update", 32'(upd_cnt - bu), 32'd0);
    full_refresh(777, 12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
